// File: rtl/fetch_stage_pkg.sv
// Shared constants, IF/ID payload type and fetch-address check for the MIPS IF stage.
package fetch_stage_pkg;

  localparam logic [31:0] DEF_PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_ENTRY  = 32'h0000_4180;
  localparam logic [31:0] DEF_IMEM_BASE  = 32'h0000_3000;
  localparam logic [31:0] DEF_IMEM_BYTES = 32'h0000_4000;
  localparam logic [31:0] NOP            = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
    logic        adel;
    logic        bd;
  } if_id_t;

  // Misaligned, or outside the [base, base+bytes) instruction window.
  function automatic logic fetch_adel(input logic [31:0] pc,
                                      input logic [31:0] base,
                                      input logic [31:0] bytes);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc >= base + bytes);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: clr (flush to bubble) beats en (load), else hold.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = DEF_PC_RESET
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en_i,
  input  logic   clr_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= '{instr: NOP, pc: PC_RESET, pc8: PC_RESET + 32'd8,
               valid: 1'b0, adel: 1'b0, bd: 1'b0};
    end else if (clr_i) begin
      // A bubble still carries the PC that was being fetched.
      q_q <= '{instr: NOP, pc: d_i.pc, pc8: d_i.pc8,
               valid: 1'b0, adel: 1'b0, bd: 1'b0};
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, next-PC selection, fetch address check and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET   = DEF_PC_RESET,
  parameter logic [31:0] EXC_ENTRY  = DEF_EXC_ENTRY,
  parameter logic [31:0] IMEM_BASE  = DEF_IMEM_BASE,
  parameter logic [31:0] IMEM_BYTES = DEF_IMEM_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_is_branch,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        id_exc_adel,
  output logic        id_bd
);

  logic [31:0] pc_q, pc_d;
  logic        adel;
  if_id_t      if_d, id_q;

  assign adel = fetch_adel(pc_q, IMEM_BASE, IMEM_BYTES);

  // NOTE: every path assigns pc_d because of the default first, so no latch.
  always_comb begin
    pc_d = pc_q;
    if (exc_req) begin
      pc_d = EXC_ENTRY;
    end else if (eret_req) begin
      pc_d = epc;
    end else if (!stall) begin
      pc_d = redirect ? redirect_pc : pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc_q <= PC_RESET;
    else       pc_q <= pc_d;
  end

  always_comb begin
    if_d.instr = adel ? NOP : imem_rdata;
    if_d.pc    = pc_q;
    if_d.pc8   = pc_q + 32'd8;
    if_d.valid = 1'b1;
    if_d.adel  = adel;
    if_d.bd    = id_is_branch;
  end

  if_id_reg #(.PC_RESET(PC_RESET)) u_if_id (
    .clk   (clk),
    .reset (reset),
    .en_i  (~stall),
    .clr_i (exc_req | eret_req),
    .d_i   (if_d),
    .q_o   (id_q)
  );

  assign imem_addr   = pc_q;
  assign id_instr    = id_q.instr;
  assign id_pc       = id_q.pc;
  assign id_pc8      = id_q.pc8;
  assign id_valid    = id_q.valid;
  assign id_exc_adel = id_q.adel;
  assign id_bd       = id_q.bd;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random control traffic.
module tb_fetch_stage;

  localparam logic [31:0] PCR   = 32'h0000_3000;
  localparam logic [31:0] EXC   = 32'h0000_4180;
  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam logic [31:0] BYTES = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, id_is_branch, exc_req, eret_req;
  logic [31:0] redirect_pc, epc, imem_rdata, imem_addr;
  logic [31:0] id_instr, id_pc, id_pc8;
  logic        id_valid, id_exc_adel, id_bd;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  assign imem_rdata = rom(imem_addr);

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_is_branch(id_is_branch),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .imem_rdata(imem_rdata), .imem_addr(imem_addr), .id_instr(id_instr),
    .id_pc(id_pc), .id_pc8(id_pc8), .id_valid(id_valid),
    .id_exc_adel(id_exc_adel), .id_bd(id_bd)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc8;
    logic        valid;
    logic        adel;
    logic        bd;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input exp_t e);
    check("imem_addr",   imem_addr,          e.pc);
    check("id_instr",    id_instr,           e.instr);
    check("id_pc",       id_pc,              e.ipc);
    check("id_pc8",      id_pc8,             e.ipc8);
    check("id_valid",    32'(id_valid),      32'(e.valid));
    check("id_exc_adel", 32'(id_exc_adel),   32'(e.adel));
    check("id_bd",       32'(id_bd),         32'(e.bd));
  endtask

  task automatic model_reset();
    m = '{pc: PCR, instr: 32'h0, ipc: PCR, ipc8: PCR + 32'd8,
          valid: 1'b0, adel: 1'b0, bd: 1'b0};
  endtask

  // Reference: a fetch is bad if the address is not a word multiple or lies
  // outside the 16 KiB window; evaluated with wide integer arithmetic.
  function automatic logic bad_fetch(input logic [31:0] a);
    longint unsigned la = longint'(a);
    return (la % 4 != 0) || (la < longint'(BASE)) || (la >= longint'(BASE) + longint'(BYTES));
  endfunction

  // Drive one cycle's controls (called at a falling edge), predict the state
  // after the next rising edge, queue it, then move to the next falling edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc,
                      input logic br, input logic ex, input logic er,
                      input logic [31:0] ep);
    logic bad;
    stall = st; redirect = rd; redirect_pc = rpc; id_is_branch = br;
    exc_req = ex; eret_req = er; epc = ep;
    bad = bad_fetch(m.pc);
    if (ex || er) begin
      m.ipc = m.pc; m.ipc8 = m.pc + 32'd8;
      m.instr = 32'h0; m.valid = 1'b0; m.adel = 1'b0; m.bd = 1'b0;
      m.pc = ex ? EXC : ep;
    end else if (!st) begin
      m.ipc = m.pc; m.ipc8 = m.pc + 32'd8;
      m.instr = bad ? 32'h0 : rom(m.pc);
      m.valid = 1'b1; m.adel = bad; m.bd = br;
      m.pc = rd ? rpc : m.pc + 32'd4;
    end
    sb.push_back(m);
    @(negedge clk);
  endtask

  task automatic nop_step();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: after each rising edge, compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check_all(e);
      end
    end
  end

  function automatic logic [31:0] rand_target();
    int unsigned k = $urandom_range(0, 9);
    if (k == 0) return BASE + ($urandom_range(0, 32'hFFF) << 2) + 32'($urandom_range(1, 3));
    if (k == 1) return $urandom();
    return BASE + ($urandom_range(0, 32'hFFF) << 2);
  endfunction

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    id_is_branch = 1'b0; exc_req = 1'b0; eret_req = 1'b0; epc = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all(m);
    reset = 1'b0;

    // Linear fetch.
    repeat (3) nop_step();
    // Taken branch: delay slot enters ID tagged, fetch moves to 3100.
    step(1'b0, 1'b1, 32'h0000_3100, 1'b1, 1'b0, 1'b0, 32'h0);
    nop_step();
    // Stall with a pending redirect, then release.
    repeat (2) step(1'b1, 1'b1, 32'h0000_3200, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_3200, 1'b0, 1'b0, 1'b0, 32'h0);
    // Exception beats stall, then eret.
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_3204);
    nop_step();
    // Exception and eret together: exception wins.
    step(1'b0, 1'b1, 32'h0000_3500, 1'b0, 1'b1, 1'b1, 32'h0000_3300);
    nop_step();
    // Address errors: misaligned, just past the window, last legal word.
    step(1'b0, 1'b1, 32'h0000_3002, 1'b0, 1'b0, 1'b0, 32'h0);
    nop_step();
    step(1'b0, 1'b1, 32'h0000_7000, 1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_6FFC, 1'b0, 1'b0, 1'b0, 32'h0);
    nop_step();
    nop_step();

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, rand_target(),
           $urandom_range(0, 2) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 29) == 0, rand_target());
    end

    // Asynchronous reset in the middle of a redirect cycle.
    redirect = 1'b1; redirect_pc = 32'h0000_3300;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all(m);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) nop_step();

    @(posedge clk);
    #2;
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
